// File: rtl/hamm_pkg.sv
// Shared definitions for the extended Hamming (8,4) SEC-DED decoder:
// syndrome-to-bit constants and the decode result record.
package hamm_pkg;

  localparam logic [2:0] SYN_C7 = 3'd7;
  localparam logic [2:0] SYN_C6 = 3'd3;
  localparam logic [2:0] SYN_C5 = 3'd5;
  localparam logic [2:0] SYN_C4 = 3'd6;
  localparam logic [2:0] SYN_C3 = 3'd1;
  localparam logic [2:0] SYN_C2 = 3'd2;
  localparam logic [2:0] SYN_C1 = 3'd4;

  typedef struct packed {
    logic [3:0] data;
    logic       corr;
    logic       uncorr;
  } dec_t;

endpackage

// File: rtl/hamm84_dec_comb.sv
// Purely combinational SEC-DED decode of one 8-bit extended Hamming codeword.
// Data lives in c[7:4]; uncorrectable words pass the raw data through.
module hamm84_dec_comb
  import hamm_pkg::*;
(
  input  logic [7:0] code,
  output dec_t       dec
);

  logic [2:0] syn;
  logic       par;
  logic [7:0] fixed;

  always_comb begin
    syn   = {code[7] ^ code[5] ^ code[4] ^ code[1],
             code[7] ^ code[6] ^ code[4] ^ code[2],
             code[7] ^ code[6] ^ code[5] ^ code[3]};
    par   = ^code;
    fixed = code;
    dec   = '0;
    if (par) begin
      // Odd overall parity: exactly one flipped bit; zero syndrome points at c0.
      case (syn)
        SYN_C7:  fixed[7] = ~code[7];
        SYN_C6:  fixed[6] = ~code[6];
        SYN_C5:  fixed[5] = ~code[5];
        SYN_C4:  fixed[4] = ~code[4];
        SYN_C3:  fixed[3] = ~code[3];
        SYN_C2:  fixed[2] = ~code[2];
        SYN_C1:  fixed[1] = ~code[1];
        default: fixed[0] = ~code[0];
      endcase
      dec.corr = 1'b1;
    end else if (syn != 3'd0) begin
      dec.uncorr = 1'b1;
    end
    dec.data = fixed[7:4];
  end

endmodule

// File: rtl/hamm_dec_arbiter.sv
// Round-robin arbiter sharing one SEC-DED decoder among NCH channels, with a
// registered response port and saturating corrected/uncorrectable counters.
module hamm_dec_arbiter
  import hamm_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int CW  = 16,
  localparam int CHW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   req_valid,
  output logic [NCH-1:0]   req_ready,
  input  logic [8*NCH-1:0] req_code,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [CHW-1:0]   rsp_ch,
  output logic [3:0]       rsp_data,
  output logic             rsp_corr,
  output logic             rsp_uncorr,
  input  logic             cnt_clr,
  output logic [CW-1:0]    corr_cnt,
  output logic [CW-1:0]    uncorr_cnt
);

  logic [CHW-1:0] rr_ptr_reg;
  logic [CHW-1:0] grant;
  logic [CHW:0]   idx;
  logic           found;
  logic           free;
  logic           xfer;
  logic           rsp_hs;
  logic [7:0]     code_arr [NCH];
  dec_t           dec;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
    assign code_arr[gi] = req_code[8*gi +: 8];
  end

  assign free   = !rsp_valid || rsp_ready;
  assign rsp_hs = rsp_valid && rsp_ready;

  // First requester at or after rr_ptr, wrapping at NCH (not necessarily a power of 2).
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = {1'b0, rr_ptr_reg} + (CHW+1)'(k);
      if (idx >= (CHW+1)'(NCH)) idx = idx - (CHW+1)'(NCH);
      if (!found && req_valid[idx[CHW-1:0]]) begin
        found = 1'b1;
        grant = idx[CHW-1:0];
      end
    end
  end

  assign xfer = reset && free && found;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant] = 1'b1;
  end

  hamm84_dec_comb u_dec (
    .code (code_arr[grant]),
    .dec  (dec)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid  <= 1'b0;
      rsp_ch     <= '0;
      rsp_data   <= '0;
      rsp_corr   <= 1'b0;
      rsp_uncorr <= 1'b0;
      rr_ptr_reg <= '0;
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else begin
      if (free) begin
        rsp_valid <= xfer;
        if (xfer) begin
          rsp_ch     <= grant;
          rsp_data   <= dec.data;
          rsp_corr   <= dec.corr;
          rsp_uncorr <= dec.uncorr;
        end
      end
      if (xfer) rr_ptr_reg <= (grant == CHW'(NCH-1)) ? '0 : grant + 1'b1;
      // Counters track delivered responses, so they advance on the output handshake.
      if (cnt_clr) begin
        corr_cnt   <= '0;
        uncorr_cnt <= '0;
      end else if (rsp_hs) begin
        if (rsp_corr && corr_cnt != '1) corr_cnt <= corr_cnt + 1'b1;
        if (rsp_uncorr && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamm_dec_arbiter.sv
// Directed bench for hamm_dec_arbiter: decode vector table, round-robin order,
// backpressure, counter saturation/clear and mid-transfer reset.
module tb_hamm_dec_arbiter;

  localparam int NCH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  req_valid;
  logic [8*NCH-1:0] req_code;
  logic            rsp_ready;
  logic            cnt_clr;

  logic [NCH-1:0]  req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_ch;
  logic [3:0]      rsp_data;
  logic            rsp_corr;
  logic            rsp_uncorr;
  logic [15:0]     corr_cnt;
  logic [15:0]     uncorr_cnt;

  logic [NCH-1:0]  s_req_ready;
  logic            s_rsp_valid;
  logic [1:0]      s_rsp_ch;
  logic [3:0]      s_rsp_data;
  logic            s_rsp_corr;
  logic            s_rsp_uncorr;
  logic [1:0]      s_corr_cnt;
  logic [1:0]      s_uncorr_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hamm_dec_arbiter #(.NCH(NCH), .CW(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_code(req_code), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ch(rsp_ch), .rsp_data(rsp_data), .rsp_corr(rsp_corr),
    .rsp_uncorr(rsp_uncorr), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt),
    .uncorr_cnt(uncorr_cnt)
  );

  // Narrow-counter instance for saturation; shares all stimulus.
  hamm_dec_arbiter #(.NCH(NCH), .CW(2)) dut_sat (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_code(req_code), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ch(s_rsp_ch), .rsp_data(s_rsp_data), .rsp_corr(s_rsp_corr),
    .rsp_uncorr(s_rsp_uncorr), .cnt_clr(cnt_clr), .corr_cnt(s_corr_cnt),
    .uncorr_cnt(s_uncorr_cnt)
  );

  typedef struct {
    logic [7:0] code;
    int         ch;
    logic [3:0] data;
    logic       corr;
    logic       uncorr;
  } vec_t;

  vec_t vecs [12];
  logic [3:0] rr_data [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic rr_run(input int n);
    req_valid = 4'hF;
    req_code  = {8'h00, 8'hFF, 8'h5A, 8'hB2};
    rsp_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      #1;
      chk($sformatf("rr%0d req_ready", k), 32'(req_ready), 32'(4'b1 << (k % 4)));
      @(posedge clk); #1;
      chk($sformatf("rr%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("rr%0d rsp_ch", k), 32'(rsp_ch), 32'(k % 4));
      chk($sformatf("rr%0d rsp_data", k), 32'(rsp_data), 32'(rr_data[k % 4]));
      $display("rr cycle %0d: ch=%0d data=%h", k, rsp_ch, rsp_data);
    end
  endtask

  initial begin
    int exp_corr;
    int exp_uncorr;

    vecs[0]  = '{8'hB2, 0, 4'hB, 1'b0, 1'b0};
    vecs[1]  = '{8'hF2, 1, 4'hB, 1'b1, 1'b0};
    vecs[2]  = '{8'hB3, 2, 4'hB, 1'b1, 1'b0};
    vecs[3]  = '{8'hD2, 3, 4'hD, 1'b0, 1'b1};
    vecs[4]  = '{8'h5A, 0, 4'h5, 1'b0, 1'b0};
    vecs[5]  = '{8'h4A, 1, 4'h5, 1'b1, 1'b0};
    vecs[6]  = '{8'h58, 2, 4'h5, 1'b1, 1'b0};
    vecs[7]  = '{8'hDA, 3, 4'h5, 1'b1, 1'b0};
    vecs[8]  = '{8'h56, 0, 4'h5, 1'b0, 1'b1};
    vecs[9]  = '{8'hCF, 1, 4'hC, 1'b0, 1'b1};
    vecs[10] = '{8'hFF, 2, 4'hF, 1'b0, 1'b0};
    vecs[11] = '{8'h00, 3, 4'h0, 1'b0, 1'b0};
    rr_data[0] = 4'hB; rr_data[1] = 4'h5; rr_data[2] = 4'hF; rr_data[3] = 4'h0;

    // Reset with requests pending: no grants, everything cleared.
    reset = 1'b0; req_valid = 4'hF; req_code = '0; rsp_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_ch/data", 32'({rsp_ch, rsp_data, rsp_corr, rsp_uncorr}), 32'd0);
    chk("reset counters", 32'({corr_cnt, uncorr_cnt}), 32'd0);
    $display("reset: rsp_valid=%0d req_ready=%b", rsp_valid, req_ready);
    reset = 1'b1; req_valid = '0;

    // Vector table, back to back with rsp_ready high.
    exp_corr = 0; exp_uncorr = 0;
    for (int i = 0; i < 12; i++) begin
      req_valid = 4'b1 << vecs[i].ch;
      req_code  = '0;
      req_code[8*vecs[i].ch +: 8] = vecs[i].code;
      #1;
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(4'b1 << vecs[i].ch));
      @(posedge clk); #1;
      if (i > 0) begin
        exp_corr   += int'(vecs[i-1].corr);
        exp_uncorr += int'(vecs[i-1].uncorr);
      end
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("v%0d rsp_ch", i), 32'(rsp_ch), 32'(vecs[i].ch));
      chk($sformatf("v%0d rsp_data", i), 32'(rsp_data), 32'(vecs[i].data));
      chk($sformatf("v%0d rsp_corr", i), 32'(rsp_corr), 32'(vecs[i].corr));
      chk($sformatf("v%0d rsp_uncorr", i), 32'(rsp_uncorr), 32'(vecs[i].uncorr));
      chk($sformatf("v%0d corr_cnt", i), 32'(corr_cnt), 32'(exp_corr));
      chk($sformatf("v%0d uncorr_cnt", i), 32'(uncorr_cnt), 32'(exp_uncorr));
      $display("vec %0d: code=%h ch=%0d data=%h corr=%0d uncorr=%0d", i, vecs[i].code,
               rsp_ch, rsp_data, rsp_corr, rsp_uncorr);
    end
    req_valid = '0;
    @(posedge clk); #1;
    chk("drain rsp_valid", 32'(rsp_valid), 32'd0);
    chk("final corr_cnt", 32'(corr_cnt), 32'd5);
    chk("final uncorr_cnt", 32'(uncorr_cnt), 32'd3);

    // All channels requesting: strict rotation.
    rr_run(5);

    // Backpressure: ch0 response held, no grants.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d held", k), 32'({rsp_valid, rsp_ch, rsp_data}), 32'({1'b1, 2'd0, 4'hB}));
      @(posedge clk); #1;
      chk($sformatf("bp%0d held after edge", k), 32'({rsp_valid, rsp_ch, rsp_data}), 32'({1'b1, 2'd0, 4'hB}));
      $display("backpressure %0d: rsp_valid=%0d ch=%0d data=%h", k, rsp_valid, rsp_ch, rsp_data);
    end
    rsp_ready = 1'b1;
    #1;
    chk("release req_ready", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    chk("release capture", 32'({rsp_valid, rsp_ch, rsp_data}), 32'({1'b1, 2'd1, 4'h5}));
    $display("release: ch=%0d data=%h", rsp_ch, rsp_data);

    // Mid-transfer reset drops the held response and rewinds the pointer.
    rsp_ready = 1'b0; reset = 1'b0;
    #1;
    chk("midreset req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("midreset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset rsp_ch/data", 32'({rsp_ch, rsp_data}), 32'd0);
    $display("mid-transfer reset: rsp_valid=%0d", rsp_valid);
    reset = 1'b1;
    rr_run(2);

    // Clear counters, then five corrected responses saturate the 2-bit counter.
    req_valid = '0; cnt_clr = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr corr_cnt", 32'(corr_cnt), 32'd0);
    req_valid = 4'b0001; req_code = {24'h0, 8'hF2};
    repeat (5) @(posedge clk);
    #1;
    req_valid = '0;
    @(posedge clk); #1;
    chk("sat wide corr_cnt", 32'(corr_cnt), 32'd5);
    chk("sat narrow corr_cnt", 32'(s_corr_cnt), 32'd3);
    $display("saturation: corr_cnt=%0d narrow=%0d", corr_cnt, s_corr_cnt);

    // Clear wins over a same-cycle increment.
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = '0; cnt_clr = 1'b1;
    chk("pre-clr pending corr", 32'({rsp_valid, rsp_corr}), 32'b11);
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr+hs corr_cnt", 32'(corr_cnt), 32'd0);
    chk("clr+hs narrow corr_cnt", 32'(s_corr_cnt), 32'd0);
    $display("clear with handshake: corr_cnt=%0d", corr_cnt);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hamm_dec_arbiter.md
# hamm_dec_arbiter

Round-robin scheduler that shares one extended Hamming (8,4) SEC-DED decode stage among `NCH` requesting channels. Each channel presents 8-bit codewords over a valid/ready handshake. The block grants one channel per cycle, decodes and corrects the codeword, and returns the 4-bit data tagged with channel ID and error flags on a single registered response port. It sits between the per-lane demappers and the nibble reassembly logic, and keeps saturating correction and uncorrectable-error counters for link monitoring.

## Interface
- `NCH`, 4, number of requesting channels (2..8)
- `CW`, 16, width of each error counter
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `req_valid`  in  NCH  per-channel codeword valid
- `req_ready`  out  NCH  per-channel accept; at most one bit high per cycle
- `req_code`  in  8*NCH  codeword of channel i at `[8*i+7:8*i]`
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  downstream accept
- `rsp_ch`  out  $clog2(NCH)  originating channel
- `rsp_data`  out  4  corrected data nibble
- `rsp_corr`  out  1  single-bit error corrected, including an error in c0
- `rsp_uncorr`  out  1  double error detected; `rsp_data` = raw c[7:4]
- `cnt_clr`  in  1  synchronous clear of both counters
- `corr_cnt`  out  CW  saturating count of `rsp_corr` responses
- `uncorr_cnt`  out  CW  saturating count of `rsp_uncorr` responses

## Operation
- Codeword bits c[7:0]. Data = c[7:4].
- Syndrome: s0 = c7^c6^c5^c3, s1 = c7^c6^c4^c2, s2 = c7^c5^c4^c1. Overall parity p = ^c[7:0].
- Syndrome-to-bit map: 7→c7, 3→c6, 5→c5, 6→c4, 1→c3, 2→c2, 4→c1.
- Decode cases:
  - s=0, p=0: clean.
  - p=1: single error. Flip the mapped bit; s=0 means the error is in c0. Set `corr`.
  - s≠0, p=0: double error. Set `uncorr`; do not correct.
- Output register is "free" when `!rsp_valid || rsp_ready`.
- Arbitration:
  - When free, grant the first requesting channel at or after `rr_ptr`, scanning upward with wrap.
  - The granted channel's `req_ready` is high that cycle. All `req_ready` bits are 0 when not free.
  - A transfer occurs when `req_valid[i] && req_ready[i]`.
  - After a transfer on channel g, `rr_ptr` ← (g+1) mod NCH. Otherwise `rr_ptr` holds.
- A transfer loads `rsp_ch`, `rsp_data`, `rsp_corr`, `rsp_uncorr` and sets `rsp_valid`.
- If the register is free and no transfer occurs, `rsp_valid` is cleared. While `rsp_valid && !rsp_ready`, all response outputs are held stable.
- Counters:
  - Increment on response handshake (`rsp_valid && rsp_ready`), not on capture.
  - Saturate at 2^CW−1.
  - `cnt_clr` takes priority over a same-cycle increment; the counter reads 0 next cycle.
- Reset (`reset`=0 at a clk edge):
  - `rsp_valid`=0, `rsp_ch`=0, `rsp_data`=0, `rsp_corr`=0, `rsp_uncorr`=0.
  - `rr_ptr`=0, both counters = 0.
  - `req_ready`=0 during reset.
  - Reset asserted mid-transfer drops the held response; it is not replayed.

## Timing
- Latency: request accepted at edge N → `rsp_valid` high after edge N, with data visible in cycle N+1.
- Throughput: one codeword per cycle with `rsp_ready` held high.
- `req_ready` is combinational from `req_valid`, `rsp_valid`, `rsp_ready` and `rr_ptr`. No combinational path from `req_code` to any output.
- Simultaneous drain and capture in one cycle is required; there is no bubble.
- Counter outputs update one cycle after the handshake.

## Structure
- Shared package `hamm_pkg`:
  - syndrome constants (`SYN_C7`=7, `SYN_C6`=3, ...)
  - decode-result struct `{data[3:0], corr, uncorr}`
- One sub-module, `hamm84_dec_comb`: purely combinational, 8-bit code in, decode struct out.
- Arbiter, output register and counters live in the top module.

## Test plan
- Reset, then channel 0 sends 8'hB2 with `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_ch`=0, `rsp_data`=4'hB, `corr`=0, `uncorr`=0.
- Single errors:
  - 8'hF2 (c6 flipped) → data 4'hB, `corr`=1.
  - 8'hB3 (c0 flipped) → data 4'hB, `corr`=1.
  - After both handshakes, `corr_cnt`=2.
- Double error: 8'hD2 → `uncorr`=1, `rsp_data`=4'hD, `corr`=0; `uncorr_cnt` increments by 1.
- All 4 channels hold `req_valid`=1 with `rsp_ready`=1 → grant order 0,1,2,3,0 on consecutive cycles; exactly one `req_ready` bit high per cycle.
- Backpressure:
  - `rsp_ready`=0 for 3 cycles with requests pending → `req_ready`=0 and response outputs stable throughout.
  - On `rsp_ready`=1 → drain and new capture in the same cycle.
- Counters and mid-transfer reset:
  - `CW`=2 with 5 corrected responses → `corr_cnt` saturates at 3.
  - `cnt_clr` in the same cycle as a handshake → counter reads 0.
  - `reset`=0 while `rsp_valid`=1 → `rsp_valid`=0 next cycle and `rr_ptr` returns to 0.
